chip8_framebuffer: RTL
======================

CHIP8_FRAMEBUFFER -- requirements
Module: chip8_framebuffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving display columns (power of two, 64 or 128).
REQ-002 The block SHALL have parameter HEIGHT, default 32, giving display rows (power of two, 32 or 64).
REQ-003 The block SHALL have parameter XW, default $clog2(WIDTH), giving the column index width; YW, default $clog2(HEIGHT), SHALL give the row index width.
REQ-004 SYS_CLK  in  1  sole clock; all state changes on its rising edge.
REQ-005 SYS_RST_N  in  1  asynchronous active-low reset.
REQ-006 cmd_valid  in  1  command offered; cmd_ready  out  1  block idle and accepting.
REQ-007 cmd_op  in  1  0 = draw sprite, 1 = clear screen.
REQ-008 cmd_x  in  8, cmd_y  in  8, cmd_n  in  4  sprite origin and row count (0..15).
REQ-009 clip_en  in  1  1 = clip pixels past right/bottom edge, 0 = wrap them; sampled at command acceptance.
REQ-010 spr_rd  out  1, spr_row  out  4  sprite row fetch request and row index; spr_data  in  8  row bits, MSB = leftmost pixel, valid the cycle after spr_rd.
REQ-011 done  out  1  one-cycle pulse at command completion; collision  out  1  VF result, valid with done and held until next acceptance.
REQ-012 vid_x  in  XW, vid_y  in  YW, vid_pix  out  1  scan-out read port, registered, 1-cycle latency.
REQ-013 vidclear  out  1  high for the whole duration of a clear command.

Function
REQ-014 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both high; cmd_ready SHALL be high only in IDLE.
REQ-015 The FSM SHALL have states IDLE, FETCH, WRITE, CLEAR, DONE.
REQ-016 Draw acceptance SHALL latch x0 = cmd_x mod WIDTH, y0 = cmd_y mod HEIGHT, cmd_n and clip_en, clear the row counter r and the collision accumulator, and go to FETCH (or DONE if cmd_n = 0).
REQ-017 In FETCH the block SHALL assert spr_rd with spr_row = r for exactly one cycle, then go to WRITE.
REQ-018 In WRITE the block SHALL XOR spr_data, placed at columns x0..x0+7, into row (y0+r); then r increments and the FSM goes to FETCH if r+1 < n, else to DONE.
REQ-019 When clip_en = 1, pixels with column >= WIDTH or row y0+r >= HEIGHT SHALL be dropped; when clip_en = 0, column and row indices SHALL wrap modulo WIDTH/HEIGHT.
REQ-020 The collision accumulator SHALL be set if any pixel written in WRITE was 1 before and 0 after; dropped pixels SHALL never set it.
REQ-021 Draw latency SHALL be exactly 2n+1 cycles from acceptance edge to done-high cycle (n = 0: done in the cycle after acceptance, collision = 0).
REQ-022 Clear acceptance SHALL go to CLEAR, zero one row per cycle from row 0 to row HEIGHT-1, then go to DONE; collision SHALL be 0 at done.
REQ-023 DONE SHALL last one cycle with done = 1 and SHALL return to IDLE.
REQ-024 vid_pix SHALL reflect memory contents as of the previous edge; a read that coincides with a WRITE of the same row SHALL return the pre-write value.
REQ-025 cmd_valid while not ready SHALL be ignored without side effects.

Reset
REQ-026 Asserting SYS_RST_N low SHALL immediately force IDLE, cmd_ready = 1, spr_rd = 0, done = 0, collision = 0, vidclear = 0, vid_pix = 0, r = 0, and all pixels to 0, including during a draw or clear in progress.
REQ-027 After reset is released, the first rising edge SHALL be able to accept a command.

Structure
REQ-028 The FSM state enum, the cmd_op encodings and the default WIDTH/HEIGHT constants SHALL reside in shared package chip8_pkg.
REQ-029 The row XOR/placement/collision logic SHALL be a combinational sub-module chip8_row_xor (inputs: old row, sprite byte, x0, clip; outputs: new row, collision).
REQ-030 Pixel storage SHALL be HEIGHT registers of WIDTH bits, updated one full row per cycle.

Verification
REQ-031 Draw at (0,0), n=1, byte 0xF0 on a blank screen -> row 0 columns 0-3 = 1, done 3 cycles after acceptance, collision = 0; repeating the same draw -> pixels back to 0, collision = 1.
REQ-032 Draw at (62,31), n=2, bytes 0xFF,0xFF, clip_en=0 -> row 31 columns 62,63,0..5 set and row 0 likewise; with clip_en=1 -> only row 31 columns 62,63 set.
REQ-033 Draw with cmd_x=70, cmd_y=40 (WIDTH=64, HEIGHT=32) -> origin at (6,8).
REQ-034 Clear after a drawing pattern -> vidclear high for 32 cycles, all pixels 0, done pulse, collision 0.
REQ-035 Assert SYS_RST_N low in the middle of a 15-row draw -> all outputs at reset values immediately, screen all 0, next command accepted normally.
REQ-036 Draw with n=0 -> no spr_rd, done the cycle after acceptance, collision 0, screen unchanged.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared constants, command encodings and FSM state type for the CHIP-8 framebuffer.
// Default geometry matches the classic 64x32 CHIP-8 display.
package chip8_pkg;

   localparam int DEF_WIDTH  = 64;
   localparam int DEF_HEIGHT = 32;

   localparam logic OP_DRAW  = 1'b0;
   localparam logic OP_CLEAR = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WRITE,
      CLEAR,
      DONE
   } fb_state_t;

endpackage

// File: rtl/chip8_row_xor.sv
// Places one sprite byte into a display row at column x0 and XORs it in.
// Reports whether any lit pixel was turned off.
module chip8_row_xor
   import chip8_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int XW    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] old_row,
   input  logic [7:0]       sprite,
   input  logic [XW-1:0]    x0,
   input  logic             clip,
   output logic [WIDTH-1:0] new_row,
   output logic             collision
);

   logic [WIDTH-1:0] mask;
   logic [XW:0]      col;

   // x0+7 never exceeds 2*WIDTH-1, so the carry bit alone marks an off-screen column
   always_comb begin
      mask = '0;
      col  = '0;
      for (int i = 0; i < 8; i++) begin
         col = {1'b0, x0} + (XW+1)'(i);
         if (sprite[3'(7 - i)] && !(clip && col[XW]))
            mask[col[XW-1:0]] = 1'b1;
      end
   end

   assign new_row   = old_row ^ mask;
   assign collision = |(old_row & mask);

endmodule

// File: rtl/chip8_framebuffer.sv
// CHIP-8 display memory: sprite XOR drawing with wrap/clip, screen clear,
// collision flag and a registered scan-out read port.
module chip8_framebuffer
   import chip8_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int HEIGHT = DEF_HEIGHT,
   parameter int XW     = $clog2(WIDTH),
   parameter int YW     = $clog2(HEIGHT)
) (
   input  logic          SYS_CLK,
   input  logic          SYS_RST_N,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_op,
   input  logic [7:0]    cmd_x,
   input  logic [7:0]    cmd_y,
   input  logic [3:0]    cmd_n,
   input  logic          clip_en,
   output logic          spr_rd,
   output logic [3:0]    spr_row,
   input  logic [7:0]    spr_data,
   output logic          done,
   output logic          collision,
   input  logic [XW-1:0] vid_x,
   input  logic [YW-1:0] vid_y,
   output logic          vid_pix,
   output logic          vidclear
);

   fb_state_t        state;
   logic [XW-1:0]    x0;
   logic [YW-1:0]    y0;
   logic [3:0]       n_q;
   logic [3:0]       r;
   logic             clip_q;
   logic [YW-1:0]    clr_row;
   logic             coll_acc;

   logic [WIDTH-1:0] mem [HEIGHT];

   logic [7:0]       row_sum;
   logic             row_in_range;
   logic [YW-1:0]    row_idx;
   logic             write_ok;
   logic [4:0]       r_next;
   logic [WIDTH-1:0] new_row;
   logic             row_coll;

   logic             mem_we;
   logic [YW-1:0]    mem_idx;
   logic [WIDTH-1:0] mem_data;

   logic             unused_bits;

   assign unused_bits = ^{cmd_x[7:XW], cmd_y[7:YW]};

   assign row_sum      = 8'(y0) + 8'(r);
   assign row_in_range = row_sum < 8'(HEIGHT);
   assign row_idx      = row_sum[YW-1:0];
   assign write_ok     = (state == WRITE) && (!clip_q || row_in_range);
   assign r_next       = {1'b0, r} + 5'd1;

   assign spr_row   = r;
   assign collision = coll_acc;

   chip8_row_xor #(
      .WIDTH (WIDTH),
      .XW    (XW)
   ) u_row_xor (
      .old_row   (mem[row_idx]),
      .sprite    (spr_data),
      .x0        (x0),
      .clip      (clip_q),
      .new_row   (new_row),
      .collision (row_coll)
   );

   always_comb begin
      mem_we   = 1'b0;
      mem_idx  = row_idx;
      mem_data = new_row;
      if (state == CLEAR) begin
         mem_we   = 1'b1;
         mem_idx  = clr_row;
         mem_data = '0;
      end else if (write_ok) begin
         mem_we   = 1'b1;
      end
   end

   // Scan-out reads the array before this edge's write lands, giving pre-write data
   always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         for (int i = 0; i < HEIGHT; i++)
            mem[i] <= '0;
         vid_pix <= 1'b0;
      end else begin
         if (mem_we)
            mem[mem_idx] <= mem_data;
         vid_pix <= mem[vid_y][vid_x];
      end
   end

   always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         spr_rd    <= 1'b0;
         done      <= 1'b0;
         vidclear  <= 1'b0;
         x0        <= '0;
         y0        <= '0;
         n_q       <= '0;
         r         <= '0;
         clip_q    <= 1'b0;
         clr_row   <= '0;
         coll_acc  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  cmd_ready <= 1'b0;
                  coll_acc  <= 1'b0;
                  r         <= '0;
                  if (cmd_op == OP_CLEAR) begin
                     clr_row  <= '0;
                     vidclear <= 1'b1;
                     state    <= CLEAR;
                  end else begin
                     x0     <= cmd_x[XW-1:0];
                     y0     <= cmd_y[YW-1:0];
                     n_q    <= cmd_n;
                     clip_q <= clip_en;
                     if (cmd_n == 4'd0) begin
                        done  <= 1'b1;
                        state <= DONE;
                     end else begin
                        spr_rd <= 1'b1;
                        state  <= FETCH;
                     end
                  end
               end
            end
            FETCH: begin
               spr_rd <= 1'b0;
               state  <= WRITE;
            end
            WRITE: begin
               if (write_ok && row_coll)
                  coll_acc <= 1'b1;
               r <= r_next[3:0];
               if (r_next < {1'b0, n_q}) begin
                  spr_rd <= 1'b1;
                  state  <= FETCH;
               end else begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            CLEAR: begin
               if (clr_row == YW'(HEIGHT - 1)) begin
                  vidclear <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  clr_row <= clr_row + 1'b1;
               end
            end
            DONE: begin
               done      <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
               spr_rd    <= 1'b0;
               done      <= 1'b0;
               vidclear  <= 1'b0;
            end
         endcase
      end
   end

endmodule
